// File: rtl/apb_timeout_guard.sv
// APB pass-through stage that completes a stuck slave access with an error after TimeoutCycles access cycles.
// Optional statistics ports (timeout count, last timeout address) are built when APB_TIMEOUT_STATS_EN is defined.
module apb_timeout_guard #(
    parameter int unsigned TimeoutCycles = 16,
    parameter logic [31:0] ErrData       = 32'hDEAD_BEEF
) (
    input  logic        apb_clk,
    input  logic        apb_rst,
    input  logic [31:0] up_req_paddr_i,
    input  logic [2:0]  up_req_pprot_i,
    input  logic        up_req_penable_i,
    input  logic        up_req_pwrite_i,
    input  logic [31:0] up_req_pwdata_i,
    input  logic [3:0]  up_req_pstrb_i,
    input  logic        up_sel_i,
    output logic        up_resp_pready_o,
    output logic [31:0] up_resp_prdata_o,
    output logic        up_resp_pslverr_o,
    output logic [31:0] dn_req_paddr_o,
    output logic [2:0]  dn_req_pprot_o,
    output logic        dn_req_penable_o,
    output logic        dn_req_pwrite_o,
    output logic [31:0] dn_req_pwdata_o,
    output logic [3:0]  dn_req_pstrb_o,
    output logic        dn_sel_o,
    input  logic        dn_resp_pready_i,
    input  logic [31:0] dn_resp_prdata_i,
    input  logic        dn_resp_pslverr_i,
`ifdef APB_TIMEOUT_STATS_EN
    output logic [15:0] timeout_count_o,
    output logic [31:0] timeout_addr_o,
`endif
    output logic        irq_timeout_o
);

    localparam bit          GuardEn  = (TimeoutCycles != 0);
    localparam logic [15:0] CntLimit = 16'(TimeoutCycles - 1);

    typedef enum logic [1:0] {PASS, ERR, DRAIN, REPLAY} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] req_paddr_q, req_paddr_d;
    logic [2:0]  req_pprot_q, req_pprot_d;
    logic        req_pwrite_q, req_pwrite_d;
    logic [31:0] req_pwdata_q, req_pwdata_d;
    logic [3:0]  req_pstrb_q, req_pstrb_d;
    logic        access;

    assign access = up_sel_i & up_req_penable_i;

    always_ff @(posedge apb_clk) begin
        if (apb_rst) begin
            state_q      <= PASS;
            cnt_q        <= '0;
            req_paddr_q  <= '0;
            req_pprot_q  <= '0;
            req_pwrite_q <= 1'b0;
            req_pwdata_q <= '0;
            req_pstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_paddr_q  <= req_paddr_d;
            req_pprot_q  <= req_pprot_d;
            req_pwrite_q <= req_pwrite_d;
            req_pwdata_q <= req_pwdata_d;
            req_pstrb_q  <= req_pstrb_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = '0;
        req_paddr_d       = req_paddr_q;
        req_pprot_d       = req_pprot_q;
        req_pwrite_d      = req_pwrite_q;
        req_pwdata_d      = req_pwdata_q;
        req_pstrb_d       = req_pstrb_q;
        irq_timeout_o     = 1'b0;
        dn_sel_o          = up_sel_i;
        dn_req_paddr_o    = up_req_paddr_i;
        dn_req_pprot_o    = up_req_pprot_i;
        dn_req_penable_o  = up_req_penable_i;
        dn_req_pwrite_o   = up_req_pwrite_i;
        dn_req_pwdata_o   = up_req_pwdata_i;
        dn_req_pstrb_o    = up_req_pstrb_i;
        up_resp_pready_o  = dn_resp_pready_i;
        up_resp_prdata_o  = dn_resp_prdata_i;
        up_resp_pslverr_o = dn_resp_pslverr_i;

        case (state_q)
            PASS: begin
                // cnt==0 marks the first access cycle of a transfer
                if (access && cnt_q == '0) begin
                    req_paddr_d  = up_req_paddr_i;
                    req_pprot_d  = up_req_pprot_i;
                    req_pwrite_d = up_req_pwrite_i;
                    req_pwdata_d = up_req_pwdata_i;
                    req_pstrb_d  = up_req_pstrb_i;
                end
                if (access && !dn_resp_pready_i) begin
                    if (GuardEn && cnt_q == CntLimit) begin
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ERR: begin
                irq_timeout_o     = 1'b1;
                up_resp_pready_o  = 1'b1;
                up_resp_pslverr_o = 1'b1;
                up_resp_prdata_o  = ErrData;
                state_d           = dn_resp_pready_i ? PASS : DRAIN;
            end
            DRAIN: begin
                up_resp_pready_o  = 1'b0;
                up_resp_pslverr_o = 1'b0;
                up_resp_prdata_o  = '0;
                if (dn_resp_pready_i) begin
                    state_d = up_sel_i ? REPLAY : PASS;
                end
            end
            REPLAY: begin
                dn_sel_o          = 1'b1;
                dn_req_penable_o  = 1'b0;
                up_resp_pready_o  = 1'b0;
                up_resp_pslverr_o = 1'b0;
                up_resp_prdata_o  = '0;
                state_d           = PASS;
            end
            default: state_d = PASS;
        endcase

        // The stuck slave access is held from the captured request until it finally completes
        if (state_q == ERR || state_q == DRAIN) begin
            dn_sel_o         = 1'b1;
            dn_req_paddr_o   = req_paddr_q;
            dn_req_pprot_o   = req_pprot_q;
            dn_req_penable_o = 1'b1;
            dn_req_pwrite_o  = req_pwrite_q;
            dn_req_pwdata_o  = req_pwdata_q;
            dn_req_pstrb_o   = req_pstrb_q;
        end

        if (apb_rst) begin
            dn_sel_o          = 1'b0;
            dn_req_penable_o  = 1'b0;
            up_resp_pready_o  = 1'b0;
            up_resp_prdata_o  = '0;
            up_resp_pslverr_o = 1'b0;
            irq_timeout_o     = 1'b0;
        end
    end

`ifdef APB_TIMEOUT_STATS_EN
    logic [15:0] stat_cnt_q, stat_cnt_d;
    logic [31:0] stat_addr_q, stat_addr_d;

    always_comb begin
        stat_cnt_d  = stat_cnt_q;
        stat_addr_d = stat_addr_q;
        if (state_q == ERR) begin
            stat_addr_d = req_paddr_q;
            if (stat_cnt_q != 16'hFFFF) begin
                stat_cnt_d = stat_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge apb_clk) begin
        if (apb_rst) begin
            stat_cnt_q  <= '0;
            stat_addr_q <= '0;
        end else begin
            stat_cnt_q  <= stat_cnt_d;
            stat_addr_q <= stat_addr_d;
        end
    end

    assign timeout_count_o = stat_cnt_q;
    assign timeout_addr_o  = stat_addr_q;
`endif

endmodule
